// File: rtl/mips_pkg.sv
// Shared types and default widths for the IF/MEM stages and the RAM port arbiter.
package mips_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MEM_LATENCY  = 2;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Purpose: picks the RAM owner from the two pending requests and the starvation flag.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module mem_arb_grant
    import mips_pkg::*;
(
    input  logic if_req,
    input  logic mem_req,
    input  logic starved,
    output logic gnt_vld,
    output logic owner
);

    always_comb begin
        gnt_vld = if_req | mem_req;
        // MEM wins a tie unless IF has already waited out the full streak
        owner   = (mem_req && !(if_req && starved)) ? OWNER_MEM : OWNER_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported RAM between fetch (IF) and load/store (MEM).
// Latency: req sampled at edge N -> ram_en in cycle N+1 -> ack in cycle N+2+MEM_LATENCY.
// Backpressure: requesters hold req until their ack; stall_* is high meanwhile.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int STK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [STK_W-1:0] streak, streak_nxt;
    logic             owner;
    logic             lat_we;
    logic             gnt_vld;
    logic             gnt_owner;
    logic             grant;
    logic             capture;

    mem_arb_grant u_grant (
        .if_req  (if_req),
        .mem_req (mem_req),
        .starved (streak == STK_MAX),
        .gnt_vld (gnt_vld),
        .owner   (gnt_owner)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Only a MEM win over a waiting IF extends the streak; anything else resets it
    always_comb begin
        streak_nxt = streak;
        if (grant) begin
            if (gnt_owner == OWNER_MEM && if_req) begin
                streak_nxt = (streak == STK_MAX) ? STK_MAX : streak + 1'b1;
            end else begin
                streak_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            streak    <= '0;
            owner     <= OWNER_IF;
            lat_we    <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            cnt     <= cnt_nxt;
            streak  <= streak_nxt;
            ram_en  <= grant;
            ram_we  <= grant && (gnt_owner == OWNER_MEM) && mem_we;
            if_ack  <= capture && (owner == OWNER_IF);
            mem_ack <= capture && (owner == OWNER_MEM);
            // ram_addr/ram_wdata double as the request latch for the whole access
            if (grant) begin
                owner     <= gnt_owner;
                lat_we    <= (gnt_owner == OWNER_MEM) && mem_we;
                ram_addr  <= (gnt_owner == OWNER_MEM) ? mem_addr : if_addr;
                ram_wdata <= (gnt_owner == OWNER_MEM) ? mem_wdata : '0;
            end
            if (capture && owner == OWNER_IF) begin
                if_rdata <= ram_rdata;
            end
            if (capture && owner == OWNER_MEM && !lat_we) begin
                mem_rdata <= ram_rdata;
            end
        end
    end

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

    a_acks_exclusive: assert property (@(posedge clk) disable iff (reset) !(if_ack && mem_ack));
    a_ram_en_single:  assert property (@(posedge clk) disable iff (reset) ram_en |=> !ram_en);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-timeline model.
module tb_mem_port_arbiter;

    localparam int L     = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ack, mem_ack, stall_if, stall_mem, ram_en, ram_we;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] ram [logic [31:0]];
    int          rd_due[$];
    logic [31:0] rd_dat[$];
    logic        prev_en = 1'b0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'h1357_9BDF ^ (a * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_word(a);
    endfunction

    // RAM device: data valid only during the cycle exactly L after the ram_en cycle, garbage otherwise
    always @(posedge clk) begin
        #1;
        while (rd_due.size() > 0 && rd_due[0] < cyc) begin
            void'(rd_due.pop_front());
            void'(rd_dat.pop_front());
        end
        if (ram_en) begin
            if (ram_we) ram[ram_addr] = ram_wdata;
            else begin
                rd_due.push_back(cyc + L);
                rd_dat.push_back(ram_rd(ram_addr));
            end
        end
        if (rd_due.size() > 0 && rd_due[0] == cyc) begin
            void'(rd_due.pop_front());
            ram_rdata = rd_dat.pop_front();
        end else begin
            ram_rdata = $urandom;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            n_tests++;
            if ((if_ack && mem_ack) !== 1'b0) begin
                n_fail++; $display("FAIL both_acks if_ack=%0b mem_ack=%0b required not both", if_ack, mem_ack);
            end
            n_tests++;
            if ((ram_en && prev_en) !== 1'b0) begin
                n_fail++; $display("FAIL ram_en_twice got two consecutive ram_en cycles at cyc %0d", cyc);
            end
        end
        prev_en = ram_en;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); if_req = 1'b1; if_addr = 32'h40;
        repeat (3) @(negedge clk);
        n_tests++; if ({ram_en, ram_we, if_ack, mem_ack} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes got=%b required=0000", {ram_en, ram_we, if_ack, mem_ack}); end
        n_tests++; if (ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_ram_bus addr=%h wdata=%h required 0", ram_addr, ram_wdata); end
        n_tests++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata if=%h mem=%h required 0", if_rdata, mem_rdata); end
        n_tests++; if (stall_if !== 1'b1 || stall_mem !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall stall_if=%b stall_mem=%b required 1/0", stall_if, stall_mem); end
        mem_req = 1'b1; #1;
        n_tests++; if (stall_mem !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall_mem got=%b required=1", stall_mem); end
        @(negedge clk); idle_inputs(); reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_tests++; if (ram_en !== 1'b0 || stall_if !== 1'b0) begin
                n_fail++; $display("FAIL reset_release ram_en=%b stall_if=%b required 0/0", ram_en, stall_if); end
        end
    endtask

    task automatic test_if_only();
        ram[32'h40] = 32'h2002_0005;
        @(negedge clk); if_req = 1'b1; if_addr = 32'h40;
        for (int i = 1; i <= L + 3; i++) begin
            @(negedge clk);
            n_tests++; if (ram_en !== (i == 1)) begin
                n_fail++; $display("FAIL ifonly_ram_en cycle %0d got=%b required=%b", i, ram_en, i == 1); end
            if (i == 1) begin
                n_tests++; if (ram_addr !== 32'h40 || ram_we !== 1'b0) begin
                    n_fail++; $display("FAIL ifonly_ram_addr addr=%h we=%b required 40/0", ram_addr, ram_we); end
            end
            n_tests++; if (if_ack !== (i == L + 2)) begin
                n_fail++; $display("FAIL ifonly_ack cycle %0d got=%b required=%b", i, if_ack, i == L + 2); end
            if (i <= L + 2) begin
                n_tests++; if (stall_if !== (i != L + 2)) begin
                    n_fail++; $display("FAIL ifonly_stall cycle %0d got=%b required=%b", i, stall_if, i != L + 2); end
            end
            if (i >= L + 2) begin
                n_tests++; if (if_rdata !== 32'h2002_0005) begin
                    n_fail++; $display("FAIL ifonly_rdata cycle %0d got=%h required=20020005", i, if_rdata); end
            end
            if (i == L + 2) if_req = 1'b0;
        end
    endtask

    task automatic test_both();
        logic [31:0] exp_m, exp_i;
        exp_m = ram_rd(32'h200); exp_i = ram_rd(32'h44);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h44;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
        for (int i = 1; i <= 2 * L + 6; i++) begin
            @(negedge clk);
            n_tests++; if (ram_en !== (i == 1 || i == L + 4)) begin
                n_fail++; $display("FAIL both_ram_en cycle %0d got=%b", i, ram_en); end
            if (i == 1 || i == L + 4) begin
                n_tests++; if (ram_addr !== ((i == 1) ? 32'h200 : 32'h44)) begin
                    n_fail++; $display("FAIL both_order cycle %0d ram_addr=%h required=%h", i, ram_addr,
                                       (i == 1) ? 32'h200 : 32'h44); end
            end
            n_tests++; if (mem_ack !== (i == L + 2) || if_ack !== (i == 2 * L + 5)) begin
                n_fail++; $display("FAIL both_acks cycle %0d mem_ack=%b if_ack=%b", i, mem_ack, if_ack); end
            if (i <= 2 * L + 5) begin
                n_tests++; if (stall_if !== (i != 2 * L + 5)) begin
                    n_fail++; $display("FAIL both_stall_if cycle %0d got=%b", i, stall_if); end
            end
            if (i == L + 2) begin
                n_tests++; if (mem_rdata !== exp_m) begin
                    n_fail++; $display("FAIL both_mem_rdata got=%h required=%h", mem_rdata, exp_m); end
                mem_req = 1'b0;
            end
            if (i == 2 * L + 5) begin
                n_tests++; if (if_rdata !== exp_i) begin
                    n_fail++; $display("FAIL both_if_rdata got=%h required=%h", if_rdata, exp_i); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_starvation();
        byte   seq[$];
        string exp_s;
        int    loads;
        exp_s = "MMMMIMM";
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; loads = 1;
        for (int c = 0; c < 300 && (if_req || mem_req); c++) begin
            @(negedge clk);
            if (ram_en) seq.push_back((ram_addr == 32'h80) ? byte'("I") : byte'("M"));
            if (mem_ack) begin
                n_tests++; if (mem_rdata !== ram_rd(mem_addr)) begin
                    n_fail++; $display("FAIL starve_mem_rdata got=%h required=%h", mem_rdata, ram_rd(mem_addr)); end
                if (loads < 6) begin mem_addr = mem_addr + 32'h4; loads++; end
                else mem_req = 1'b0;
            end
            if (if_ack) begin
                n_tests++; if (if_rdata !== ram_rd(32'h80)) begin
                    n_fail++; $display("FAIL starve_if_rdata got=%h required=%h", if_rdata, ram_rd(32'h80)); end
                if_req = 1'b0;
            end
        end
        for (int j = 0; j < 7; j++) begin
            n_tests++;
            if (j >= seq.size()) begin
                n_fail++; $display("FAIL starve_order grant %0d missing (only %0d grants)", j, seq.size());
            end else if (seq[j] != exp_s[j]) begin
                n_fail++; $display("FAIL starve_order grant %0d got=%c required=%c", j, seq[j], exp_s[j]);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] exp_prev;
        exp_prev = ram_rd(32'h314);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= L + 2; i++) begin
            @(negedge clk);
            n_tests++; if (ram_en !== (i == 1) || mem_ack !== (i == L + 2)) begin
                n_fail++; $display("FAIL store_timing cycle %0d ram_en=%b mem_ack=%b", i, ram_en, mem_ack); end
            if (i == 1) begin
                n_tests++; if (ram_we !== 1'b1 || ram_addr !== 32'h100 || ram_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL store_bus we=%b addr=%h wdata=%h required 1/100/deadbeef",
                                       ram_we, ram_addr, ram_wdata); end
            end
            if (i == L + 2) begin
                n_tests++; if (mem_rdata !== exp_prev) begin
                    n_fail++; $display("FAIL store_rdata_kept got=%h required=%h", mem_rdata, exp_prev); end
                mem_req = 1'b0;
            end
        end
        @(negedge clk); mem_req = 1'b1; mem_we = 1'b0;
        for (int i = 1; i <= L + 2; i++) begin
            @(negedge clk);
            if (i == L + 2) begin
                n_tests++; if (mem_ack !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL store_readback ack=%b rdata=%h required 1/deadbeef", mem_ack, mem_rdata); end
                mem_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_wait();
        int mem_grants;
        mem_grants = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h48;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h400;
        for (int c = 0; c < 100 && mem_grants < 4; c++) begin
            @(negedge clk);
            if (ram_en && ram_addr != 32'h48) mem_grants++;
            if (mem_ack && mem_grants < 4) mem_addr = mem_addr + 32'h4;
        end
        n_tests++; if (mem_grants != 4) begin
            n_fail++; $display("FAIL rstwait_setup mem grants=%0d required=4", mem_grants); end
        @(negedge clk); reset = 1'b1; #1;
        n_tests++; if ({ram_en, if_ack, mem_ack} !== 3'b0 || if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstwait_clear en/acks=%b if_rdata=%h mem_rdata=%h required 0",
                               {ram_en, if_ack, mem_ack}, if_rdata, mem_rdata); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 2 * L + 5; i++) begin
            @(negedge clk);
            n_tests++; if (mem_ack !== (i == L + 2) || if_ack !== (i == 2 * L + 5)) begin
                n_fail++; $display("FAIL rstwait_acks cycle %0d mem_ack=%b if_ack=%b", i, mem_ack, if_ack); end
            if (i == 1) begin
                n_tests++; if (ram_en !== 1'b1 || ram_addr !== mem_addr) begin
                    n_fail++; $display("FAIL rstwait_streak ram_en=%b addr=%h required 1/%h", ram_en, ram_addr, mem_addr); end
            end
            if (i == L + 2) begin
                n_tests++; if (mem_rdata !== ram_rd(mem_addr)) begin
                    n_fail++; $display("FAIL rstwait_mem_rdata got=%h required=%h", mem_rdata, ram_rd(mem_addr)); end
                mem_req = 1'b0;
            end
            if (i == 2 * L + 5) begin
                n_tests++; if (if_rdata !== ram_rd(32'h48)) begin
                    n_fail++; $display("FAIL rstwait_if_rdata got=%h required=%h", if_rdata, ram_rd(32'h48)); end
                if_req = 1'b0;
            end
        end
    endtask

    // Timeline model: each grant occupies the port for L+3 cycles, ram_en one cycle in, ack L+2 cycles in
    task automatic test_random();
        logic [31:0] ref_mem [logic [31:0]];
        int          en_c, ack_c, free_c, run, t;
        bit          own_mem, g_we, if_gr, mem_gr, exp_en, ia, ma;
        logic [31:0] g_addr, g_wdata, g_data, e_if, e_mem;
        en_c = -1; ack_c = -1; run = 0; own_mem = 1'b0; g_we = 1'b0;
        if_gr = 1'b0; mem_gr = 1'b0; g_addr = '0; g_wdata = '0; g_data = '0;
        e_if = '0; e_mem = '0;
        @(negedge clk); reset = 1'b1; idle_inputs();
        @(negedge clk); reset = 1'b0;
        ref_mem = ram;
        free_c = cyc;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            t = cyc;
            exp_en = (t == en_c);
            ia = (t == ack_c) && !own_mem;
            ma = (t == ack_c) && own_mem;
            if (ia) e_if = g_data;
            if (ma && !g_we) e_mem = g_data;
            n_tests++; if (ram_en !== exp_en || if_ack !== ia || mem_ack !== ma) begin
                n_fail++; $display("FAIL rand_strobes cyc %0d en/if_ack/mem_ack=%b%b%b required %b%b%b",
                                   t, ram_en, if_ack, mem_ack, exp_en, ia, ma); end
            n_tests++; if (if_rdata !== e_if || mem_rdata !== e_mem) begin
                n_fail++; $display("FAIL rand_rdata cyc %0d if=%h mem=%h required %h/%h", t, if_rdata, mem_rdata, e_if, e_mem); end
            if (exp_en) begin
                n_tests++; if (ram_addr !== g_addr || ram_we !== g_we || (g_we && ram_wdata !== g_wdata)) begin
                    n_fail++; $display("FAIL rand_ram_bus cyc %0d addr=%h we=%b wdata=%h required %h/%b/%h",
                                       t, ram_addr, ram_we, ram_wdata, g_addr, g_we, g_wdata); end
            end
            if (ia) begin
                if_gr = 1'b0; if_req = ($urandom_range(0, 1) == 1); if_addr = 32'($urandom_range(0, 31)) << 2;
            end else if (if_gr) begin
                if ($urandom_range(0, 3) == 0) if_addr = $urandom;
                if ($urandom_range(0, 7) == 0) if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 32'($urandom_range(0, 31)) << 2;
            end
            if (ma || (!mem_gr && !mem_req && $urandom_range(0, 2) == 0)) begin
                mem_gr = 1'b0; mem_req = ma ? ($urandom_range(0, 1) == 1) : 1'b1;
                mem_we = ($urandom_range(0, 2) == 0); mem_wdata = $urandom;
                mem_addr = 32'($urandom_range(0, 31)) << 2;
            end else if (mem_gr) begin
                if ($urandom_range(0, 3) == 0) begin mem_addr = $urandom; mem_wdata = $urandom; mem_we = ~mem_we; end
                if ($urandom_range(0, 7) == 0) mem_req = 1'b0;
            end
            #1;
            n_tests++; if (stall_if !== (if_req && !ia) || stall_mem !== (mem_req && !ma)) begin
                n_fail++; $display("FAIL rand_stall cyc %0d stall_if=%b stall_mem=%b required %b/%b",
                                   t, stall_if, stall_mem, if_req && !ia, mem_req && !ma); end
            if (t >= free_c && (if_req || mem_req)) begin
                own_mem = mem_req && !(if_req && run == LIMIT);
                if (own_mem && if_req) run = (run < LIMIT) ? run + 1 : LIMIT;
                else run = 0;
                g_addr  = own_mem ? mem_addr : if_addr;
                g_we    = own_mem && mem_we;
                g_wdata = mem_wdata;
                if (g_we) ref_mem[g_addr] = g_wdata;
                else g_data = ref_mem.exists(g_addr) ? ref_mem[g_addr] : init_word(g_addr);
                if (own_mem) mem_gr = 1'b1; else if_gr = 1'b1;
                en_c = t + 1; ack_c = t + L + 2; free_c = t + L + 3;
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        ram_rdata = '0;
        test_reset();
        test_if_only();
        test_both();
        test_starvation();
        test_store();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
